pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB): detects RAW hazards between the ID-stage consumer
//  and EX/MEM/WB producers, then stalls PC and IF/ID while injecting ID/EX bubbles.
//  Flushes IF/ID, ID/EX and EX/MEM when a branch resolves taken in MEM.
//  Drives the write_en/flush inputs of the pipeline gen_registers; keeps saturating stall and flush counters.
// PARAMETERS
//  CNT_W  16  width of stall_cycles / flush_events counters (saturating)
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous reset, active-low
//  ifid_rs         in   5      IF/ID instr[25:21]
//  ifid_rt         in   5      IF/ID instr[20:16]
//  ifid_uses_rt    in   1      ID instr reads rt (R-type, beq, sw)
//  idex_rs/idex_rt in   5 each ID/EX source regs (forwarding compare)
//  idex_wr_reg     in   5      ID/EX destination after reg_dst mux
//  idex_reg_write  in   1      ID/EX reg_write
//  idex_mem_read   in   1      ID/EX mem_read (load in EX)
//  exmem_wr_reg    in   5      EX/MEM destination
//  exmem_reg_write in   1      EX/MEM reg_write
//  memwb_wr_reg    in   5      MEM/WB destination
//  memwb_reg_write in   1      MEM/WB reg_write
//  branch_taken    in   1      EXMEM_branch & EXMEM_zero
//  pc_write_en     out  1      PC register enable
//  ifid_write_en   out  1      IF/ID enable
//  ifid_flush      out  1      clear IF/ID on next edge
//  idex_flush      out  1      load bubble (all controls 0) into ID/EX
//  exmem_flush     out  1      clear EX/MEM controls
//  fwd_a_sel       out  2      EX operand A: 00 regfile, 10 EX/MEM alu_result, 01 MEM/WB write data
//  fwd_b_sel       out  2      EX operand B, same encoding
//  id_bypass_rs    out  1      ID reads MEM/WB write data for rs
//  id_bypass_rt    out  1      ID reads MEM/WB write data for rt
//  stall_active    out  1      1 while FSM in STALL or stall issued this cycle
//  stall_cycles    out  CNT_W  total stall cycles since reset
//  flush_events    out  CNT_W  total taken-branch flushes since reset
// BEHAVIOUR
//  - Reset (rst==0 at edge): state=RUN, cnt=0, counters=0. Outputs while in reset: pc_write_en=1,
//    ifid_write_en=1, all flush=0, fwd=00, bypass=0, stall_active=0.
//  - Hazard match: producer reg_write==1, producer wr_reg!=0, and wr_reg==ifid_rs, or
//    (ifid_uses_rt && wr_reg==ifid_rt). Register $0 never hazards.
//  - Stall need N: without FORWARDING_EN, match vs ID/EX->3, EX/MEM->2, MEM/WB->1; largest N wins.
//    With FORWARDING_EN, only ID/EX match with idex_mem_read=1 gives N=1; otherwise N=0.
//  - FSM RUN: N>0 -> stall this cycle (pc_write_en=0, ifid_write_en=0, idex_flush=1); stall_active=1;
//    if N>1 go to STALL with cnt=N-1.
//  - FSM STALL: same stall outputs; cnt decrements; cnt==1 -> RUN next edge. Total stall = exactly N cycles.
//    Hazard inputs are ignored in STALL (ID/EX holds bubbles).
//  - Branch priority: branch_taken=1 in any state -> ifid_flush=idex_flush=exmem_flush=1,
//    pc_write_en=1, ifid_write_en=1. FSM forced to RUN, cnt=0; any pending stall is abandoned.
//    flush_events increments.
//  - Counters: stall_cycles += 1 each cycle with stall_active=1 and branch_taken=0.
//    Both counters saturate at all-ones, with no wrap.
//  - Stall/flush/fwd/bypass outputs are combinational from inputs+state (zero latency).
//    State and counters are registered.
// CONFIGURATION
//  FORWARDING_EN defined:
//   - fwd_x_sel=10 if exmem_reg_write && exmem_wr_reg!=0 && ==idex_rx;
//     else 01 if the same match holds on MEM/WB; else 00. EX/MEM has priority.
//   - id_bypass_rx=1 on a MEM/WB match vs ifid_rx (rx != 0).
//  FORWARDING_EN undefined: fwd_*=00 and id_bypass_*=0 constantly; full-stall N rules apply.
// TESTING
//  1 no-fwd: add $3,$1,$2 then sub $4,$3,$1 -> 3 stall cycles, pc held, 3 ID/EX bubbles, stall_cycles=3.
//  2 no-fwd: ID/EX producer $5 match, branch_taken at 2nd stall cycle -> 3 flushes that cycle, RUN next,
//    stall_cycles=1, flush_events=1.
//  3 FORWARDING_EN: lw $2,0($0) then add $3,$2,$2 -> 1 stall, then fwd_a_sel=fwd_b_sel=01.
//  4 FORWARDING_EN: add $3 then add $4,$3,$3 -> 0 stalls, fwd_a_sel=10; EX/MEM and MEM/WB both $3 -> 10.
//  5 producer wr_reg=$0 with reg_write=1 -> no stall, fwd=00. rst=0 mid-STALL -> RUN, counters 0 next edge.
//  6 force stall_cycles to 16'hFFFF, then stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Groups the hazard-controller signals of the 5-stage pipeline into one bundle.
//   master : pipeline datapath side. Drives register/control fields and reads
//            the enables, flushes and forwarding selects.
//   slave  : hazard controller side. Reads the fields and drives the controls.
// Fields:
//   ifid_rs/ifid_rt/ifid_uses_rt         ID-stage consumer source registers
//   idex_rs/idex_rt                      EX-stage source registers (forwarding)
//   idex_wr_reg/idex_reg_write/idex_mem_read   ID/EX producer
//   exmem_wr_reg/exmem_reg_write         EX/MEM producer
//   memwb_wr_reg/memwb_reg_write         MEM/WB producer
//   branch_taken                         taken branch resolved in MEM
//   pc_write_en/ifid_write_en            stage enables
//   ifid_flush/idex_flush/exmem_flush    stage clears / bubble injection
//   fwd_a_sel/fwd_b_sel                  EX operand muxes (00 rf, 10 EX/MEM, 01 MEM/WB)
//   id_bypass_rs/id_bypass_rt            ID read of MEM/WB write data
//   stall_active                         a stall cycle is in progress
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic [4:0] idex_rs;
  logic [4:0] idex_rt;
  logic [4:0] idex_wr_reg;
  logic       idex_reg_write;
  logic       idex_mem_read;
  logic [4:0] exmem_wr_reg;
  logic       exmem_reg_write;
  logic [4:0] memwb_wr_reg;
  logic       memwb_reg_write;
  logic       branch_taken;

  logic       pc_write_en;
  logic       ifid_write_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       id_bypass_rs;
  logic       id_bypass_rt;
  logic       stall_active;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_rs, idex_rt,
    output idex_wr_reg, idex_reg_write, idex_mem_read,
    output exmem_wr_reg, exmem_reg_write, memwb_wr_reg, memwb_reg_write,
    output branch_taken,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_flush, exmem_flush,
    input  fwd_a_sel, fwd_b_sel, id_bypass_rs, id_bypass_rt, stall_active
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_rs, idex_rt,
    input  idex_wr_reg, idex_reg_write, idex_mem_read,
    input  exmem_wr_reg, exmem_reg_write, memwb_wr_reg, memwb_reg_write,
    input  branch_taken,
    output pc_write_en, ifid_write_en, ifid_flush, idex_flush, exmem_flush,
    output fwd_a_sel, fwd_b_sel, id_bypass_rs, id_bypass_rt, stall_active
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard detection / stall / flush sequencer for a 5-stage IF/ID/EX/MEM/WB
// pipeline. RAW hazards between the ID consumer and the EX/MEM/WB producers
// stall PC and IF/ID for N cycles while ID/EX is loaded with bubbles. A taken
// branch resolved in MEM flushes IF/ID, ID/EX and EX/MEM and overrides any
// stall. Saturating counters track stall cycles and taken-branch flushes.
//
// Optional feature: define FORWARDING_EN to enable EX-stage forwarding and the
// ID-stage MEM/WB bypass; only load-use then stalls (1 cycle). Without it the
// forwarding/bypass outputs are constant 0 and full-stall rules apply.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-low
//   bus           pipeline_hazard_ctrl_if.slave (fields/controls, see interface)
//   stall_cycles  CNT_W saturating count of stall cycles since reset
//   flush_events  CNT_W saturating count of taken-branch flushes since reset
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_reg, state_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_events_reg;

  logic [1:0] need;          // stall cycles required by the current ID instruction
  logic       stall_issue;   // this cycle is a stall cycle (before branch override)
  logic [1:0] fwd_sel [2];
  logic       bypass  [2];

  // Producer hazards against the ID consumer; $0 never hazards.
  function automatic logic id_match(input logic       rw,
                                    input logic [4:0] wr,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       uses_rt);
    return rw && (wr != 5'd0) && ((wr == rs) || (uses_rt && (wr == rt)));
  endfunction

  logic match_idex, match_exmem, match_memwb;
  assign match_idex  = id_match(bus.idex_reg_write,  bus.idex_wr_reg,
                                bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt);
  assign match_exmem = id_match(bus.exmem_reg_write, bus.exmem_wr_reg,
                                bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt);
  assign match_memwb = id_match(bus.memwb_reg_write, bus.memwb_wr_reg,
                                bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt);

`ifdef FORWARDING_EN
  logic [4:0] ex_src [2];
  logic [4:0] id_src [2];
  assign ex_src[0] = bus.idex_rs;
  assign ex_src[1] = bus.idex_rt;
  assign id_src[0] = bus.ifid_rs;
  assign id_src[1] = bus.ifid_rt;

  // Only a load in EX cannot be forwarded in time: one bubble resolves it.
  assign need = (match_idex && bus.idex_mem_read) ? 2'd1 : 2'd0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_exmem, hit_memwb;
    assign hit_exmem = bus.exmem_reg_write && (bus.exmem_wr_reg != 5'd0) &&
                       (bus.exmem_wr_reg == ex_src[gi]);
    assign hit_memwb = bus.memwb_reg_write && (bus.memwb_wr_reg != 5'd0) &&
                       (bus.memwb_wr_reg == ex_src[gi]);
    // EX/MEM holds the younger result, so it wins over MEM/WB.
    assign fwd_sel[gi] = hit_exmem ? 2'b10 : (hit_memwb ? 2'b01 : 2'b00);
    assign bypass[gi]  = bus.memwb_reg_write && (bus.memwb_wr_reg != 5'd0) &&
                         (bus.memwb_wr_reg == id_src[gi]);
  end

  logic unused_ok;
  assign unused_ok = 1'b0;
`else
  // Without forwarding the consumer waits until the producer has written back.
  assign need = match_idex  ? 2'd3 :
                match_exmem ? 2'd2 :
                match_memwb ? 2'd1 : 2'd0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] = 2'b00;
    assign bypass[gi]  = 1'b0;
  end

  logic unused_ok;
  assign unused_ok = ^{bus.idex_rs, bus.idex_rt, bus.idex_mem_read};
`endif

  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    bus.pc_write_en     = 1'b1;
    bus.ifid_write_en   = 1'b1;
    bus.ifid_flush      = 1'b0;
    bus.idex_flush      = 1'b0;
    bus.exmem_flush     = 1'b0;
    bus.stall_active    = 1'b0;

    // In STALL the hazard inputs are ignored: ID/EX only carries bubbles.
    stall_issue = (state_reg == ST_STALL) || (need != 2'd0);

    if (state_reg == ST_STALL) begin
      if (cnt_reg == 2'd1) begin
        state_next = ST_RUN;
        cnt_next   = 2'd0;
      end else begin
        cnt_next = cnt_reg - 2'd1;
      end
    end else if (need > 2'd1) begin
      state_next = ST_STALL;
      cnt_next   = need - 2'd1;
    end

    if (stall_issue) begin
      bus.pc_write_en   = 1'b0;
      bus.ifid_write_en = 1'b0;
      bus.idex_flush    = 1'b1;
      bus.stall_active  = 1'b1;
    end

    // A taken branch squashes the wrong-path instructions, including any
    // stalled consumer, so the pending stall is simply dropped.
    if (bus.branch_taken) begin
      bus.pc_write_en   = 1'b1;
      bus.ifid_write_en = 1'b1;
      bus.ifid_flush    = 1'b1;
      bus.idex_flush    = 1'b1;
      bus.exmem_flush   = 1'b1;
      state_next        = ST_RUN;
      cnt_next          = 2'd0;
    end

    if (!rst) begin
      bus.pc_write_en   = 1'b1;
      bus.ifid_write_en = 1'b1;
      bus.ifid_flush    = 1'b0;
      bus.idex_flush    = 1'b0;
      bus.exmem_flush   = 1'b0;
      bus.stall_active  = 1'b0;
    end
  end

  assign bus.fwd_a_sel    = rst ? fwd_sel[0] : 2'b00;
  assign bus.fwd_b_sel    = rst ? fwd_sel[1] : 2'b00;
  assign bus.id_bypass_rs = rst && bypass[0];
  assign bus.id_bypass_rt = rst && bypass[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= ST_RUN;
      cnt_reg          <= 2'd0;
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (stall_issue && !bus.branch_taken && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
      if (bus.branch_taken && (flush_events_reg != '1))
        flush_events_reg <= flush_events_reg + CNT_ONE;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed-vector bench for pipeline_hazard_ctrl. Expected values are
// hand-computed from the stall/flush/forwarding rules. Builds with or
// without FORWARDING_EN; each build runs the vectors that apply to it.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0; bus.ifid_uses_rt = 1'b0;
    bus.idex_rs = 5'd0; bus.idex_rt = 5'd0;
    bus.idex_wr_reg = 5'd0; bus.idex_reg_write = 1'b0; bus.idex_mem_read = 1'b0;
    bus.exmem_wr_reg = 5'd0; bus.exmem_reg_write = 1'b0;
    bus.memwb_wr_reg = 5'd0; bus.memwb_reg_write = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Stall cycle outputs: pc/ifid held, bubble into ID/EX.
  task automatic check_stall(input string tag, input logic exp_stall);
    settle();
    check_eq({tag, " pc_we"},  bus.pc_write_en,  !exp_stall);
    check_eq({tag, " idex_fl"}, bus.idex_flush,  exp_stall);
  endtask

  initial begin
    int n;
    clear_inputs();

    // Reset: outputs forced to defaults even with a live hazard present.
    tick();
    bus.idex_wr_reg = 5'd3; bus.idex_reg_write = 1'b1; bus.ifid_rs = 5'd3;
    bus.idex_mem_read = 1'b1; bus.branch_taken = 1'b1;
    settle();
    check_eq("rst pc_we",    bus.pc_write_en,   1);
    check_eq("rst ifid_we",  bus.ifid_write_en, 1);
    check_eq("rst flushes",  {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 0);
    check_eq("rst stall",    bus.stall_active,  0);
    check_eq("rst fwd",      {bus.fwd_a_sel, bus.fwd_b_sel}, 0);
    tick();
    check_eq("rst stall_cnt", stall_cycles, 0);
    check_eq("rst flush_cnt", flush_events, 0);
    clear_inputs();
    rst = 1'b1;
    tick();

    // $0 producer never hazards.
    bus.idex_wr_reg = 5'd0; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    bus.exmem_wr_reg = 5'd0; bus.exmem_reg_write = 1'b1;
    bus.ifid_rs = 5'd0; bus.idex_rs = 5'd0;
    check_stall("r0", 1'b0);
    check_eq("r0 fwd_a", bus.fwd_a_sel, 0);
    clear_inputs();
    tick();

`ifndef FORWARDING_EN
    // add $3,$1,$2 in ID/EX ; sub $4,$3,$1 in ID -> 3 stall cycles.
    do_reset();
    bus.idex_wr_reg = 5'd3; bus.idex_reg_write = 1'b1;
    bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd1; bus.ifid_uses_rt = 1'b1;
    check_stall("t1 c0", 1'b1);
    check_eq("t1 c0 ifid_we", bus.ifid_write_en, 0);
    tick();
    bus.idex_reg_write = 1'b0;
    bus.exmem_wr_reg = 5'd3; bus.exmem_reg_write = 1'b1;
    check_stall("t1 c1", 1'b1);
    tick();
    bus.exmem_reg_write = 1'b0;
    bus.memwb_wr_reg = 5'd3; bus.memwb_reg_write = 1'b1;
    check_stall("t1 c2", 1'b1);
    check_eq("t1 c2 act", bus.stall_active, 1);
    tick();
    clear_inputs();
    check_stall("t1 c3", 1'b0);
    check_eq("t1 stall_cnt", stall_cycles, 3);

    // EX/MEM match on rt -> 2 cycles; ignored rt when not used -> none.
    do_reset();
    bus.exmem_wr_reg = 5'd9; bus.exmem_reg_write = 1'b1;
    bus.ifid_rs = 5'd1; bus.ifid_rt = 5'd9; bus.ifid_uses_rt = 1'b1;
    check_stall("exm c0", 1'b1);
    tick();
    clear_inputs();
    check_stall("exm c1", 1'b1);
    tick();
    check_stall("exm c2", 1'b0);
    check_eq("exm stall_cnt", stall_cycles, 2);
    bus.memwb_wr_reg = 5'd9; bus.memwb_reg_write = 1'b1;
    bus.ifid_rt = 5'd9; bus.ifid_uses_rt = 1'b0;
    check_stall("rt unused", 1'b0);
    bus.ifid_uses_rt = 1'b1;
    check_stall("memwb rt", 1'b1);
    tick();
    clear_inputs();
    check_stall("memwb done", 1'b0);
    check_eq("memwb stall_cnt", stall_cycles, 3);

    // Branch taken on the 2nd stall cycle of an ID/EX $5 hazard.
    do_reset();
    bus.idex_wr_reg = 5'd5; bus.idex_reg_write = 1'b1; bus.ifid_rs = 5'd5;
    check_stall("t2 c0", 1'b1);
    tick();
    clear_inputs();
    bus.branch_taken = 1'b1;
    settle();
    check_eq("t2 flushes", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 3'b111);
    check_eq("t2 pc_we",   bus.pc_write_en, 1);
    check_eq("t2 ifid_we", bus.ifid_write_en, 1);
    tick();
    bus.branch_taken = 1'b0;
    check_stall("t2 run", 1'b0);
    check_eq("t2 exm_fl", bus.exmem_flush, 0);
    check_eq("t2 stall_cnt", stall_cycles, 1);
    check_eq("t2 flush_cnt", flush_events, 1);

    // Reset asserted mid-STALL.
    bus.idex_wr_reg = 5'd6; bus.idex_reg_write = 1'b1; bus.ifid_rs = 5'd6;
    tick();
    clear_inputs();
    rst = 1'b0;
    settle();
    check_eq("t5 rst pc_we", bus.pc_write_en, 1);
    tick();
    rst = 1'b1;
    check_stall("t5 run", 1'b0);
    check_eq("t5 stall_cnt", stall_cycles, 0);
    check_eq("t5 flush_cnt", flush_events, 0);
`else
    // lw $2,0($0) in ID/EX ; add $3,$2,$2 in ID -> 1 stall.
    do_reset();
    bus.idex_wr_reg = 5'd2; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    bus.ifid_rs = 5'd2; bus.ifid_rt = 5'd2; bus.ifid_uses_rt = 1'b1;
    check_stall("t3 c0", 1'b1);
    tick();
    clear_inputs();
    bus.exmem_wr_reg = 5'd2; bus.exmem_reg_write = 1'b1; bus.exmem_wr_reg = 5'd2;
    bus.ifid_rs = 5'd2; bus.ifid_rt = 5'd2; bus.ifid_uses_rt = 1'b1;
    check_stall("t3 c1", 1'b0);
    tick();
    clear_inputs();
    bus.idex_rs = 5'd2; bus.idex_rt = 5'd2;
    bus.memwb_wr_reg = 5'd2; bus.memwb_reg_write = 1'b1;
    settle();
    check_eq("t3 fwd_a", bus.fwd_a_sel, 2'b01);
    check_eq("t3 fwd_b", bus.fwd_b_sel, 2'b01);
    check_eq("t3 stall_cnt", stall_cycles, 1);

    // add $3 ; add $4,$3,$3 -> no stall, EX/MEM forward wins over MEM/WB.
    clear_inputs();
    bus.idex_wr_reg = 5'd3; bus.idex_reg_write = 1'b1; bus.ifid_rs = 5'd3;
    check_stall("t4 nostall", 1'b0);
    clear_inputs();
    bus.idex_rs = 5'd3; bus.idex_rt = 5'd3;
    bus.exmem_wr_reg = 5'd3; bus.exmem_reg_write = 1'b1;
    settle();
    check_eq("t4 fwd_a", bus.fwd_a_sel, 2'b10);
    bus.memwb_wr_reg = 5'd3; bus.memwb_reg_write = 1'b1;
    settle();
    check_eq("t4 both fwd_a", bus.fwd_a_sel, 2'b10);
    check_eq("t4 both fwd_b", bus.fwd_b_sel, 2'b10);

    // ID bypass from MEM/WB on rs only.
    clear_inputs();
    bus.memwb_wr_reg = 5'd7; bus.memwb_reg_write = 1'b1;
    bus.ifid_rs = 5'd7; bus.ifid_rt = 5'd8;
    check_stall("byp nostall", 1'b0);
    check_eq("byp rs", bus.id_bypass_rs, 1);
    check_eq("byp rt", bus.id_bypass_rt, 0);
    clear_inputs();

    // Branch during a load-use stall.
    do_reset();
    bus.idex_wr_reg = 5'd4; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    bus.ifid_rs = 5'd4; bus.branch_taken = 1'b1;
    settle();
    check_eq("br flushes", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 3'b111);
    check_eq("br pc_we", bus.pc_write_en, 1);
    tick();
    clear_inputs();
    check_eq("br stall_cnt", stall_cycles, 0);
    check_eq("br flush_cnt", flush_events, 1);
`endif

    // Saturation: a held load-use hazard stalls every cycle in either build.
    clear_inputs();
    do_reset();
    bus.idex_wr_reg = 5'd1; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    bus.ifid_rs = 5'd1;
    n = 0;
    while (stall_cycles != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    check_eq("sat reached", stall_cycles, 16'hFFFF);
    check_eq("sat cycles", n, 65535);
    tick();
    tick();
    check_eq("sat hold", stall_cycles, 16'hFFFF);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
